// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser followed by a mid-bit sampling FSM that
// deserialises LSB-first frames and reports data, framing error and break.
module uart_rx #(
    parameter int unsigned BIT_RATE       = 9600,
    parameter int unsigned CLK_FREQ       = 50_000_000,
    parameter int unsigned PAYLOAD_WIDTH  = 8,
    parameter int unsigned STOP_BITS      = 1,
    parameter int unsigned CYCLES_PER_BIT = CLK_FREQ / BIT_RATE,
    parameter int unsigned HALF_BIT       = CYCLES_PER_BIT / 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     uart_rxd,
    input  logic                     uart_rx_en,
    output logic [PAYLOAD_WIDTH-1:0] uart_rx_data,
    output logic                     uart_rx_valid,
    output logic                     uart_rx_frame_err,
    output logic                     uart_rx_break,
    output logic                     uart_rx_busy
);

    localparam int unsigned CNT_W = $clog2(CYCLES_PER_BIT);
    localparam int unsigned BIT_W = 4;

    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_DATA    = BIT_W'(PAYLOAD_WIDTH - 1);
    localparam logic [BIT_W-1:0] LAST_STOP    = BIT_W'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RECV  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cyc_q, cyc_d;
    logic [BIT_W-1:0]         bit_q, bit_d;
    logic [PAYLOAD_WIDTH-1:0] shift_q, shift_d;
    logic                     err_q, err_d;
    logic [PAYLOAD_WIDTH-1:0] data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     ferr_q, ferr_d;
    logic                     brk_q, brk_d;
    logic                     sync1_q, rxd_sync_q;

    // Register bank, including the metastability synchroniser on uart_rxd.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cyc_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            err_q      <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
            sync1_q    <= 1'b1;
            rxd_sync_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            err_q      <= err_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            brk_q      <= brk_d;
            sync1_q    <= uart_rxd;
            rxd_sync_q <= sync1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        err_d   = err_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = ferr_q;
        brk_d   = brk_q;

        unique case (state_q)
            IDLE: begin
                if (uart_rx_en && !rxd_sync_q) begin
                    state_d = START;
                    cyc_d   = '0;
                end
            end
            START: begin
                // Re-check the line at mid-start-bit to reject glitches.
                if (cyc_q == CNT_HALF_END) begin
                    state_d = rxd_sync_q ? IDLE : RECV;
                    cyc_d   = '0;
                    bit_d   = '0;
                end else begin
                    cyc_d = cyc_q + CNT_W'(1);
                end
            end
            RECV: begin
                if (cyc_q == CNT_BIT_END) begin
                    cyc_d   = '0;
                    shift_d = {rxd_sync_q, shift_q[PAYLOAD_WIDTH-1:1]};
                    if (bit_q == LAST_DATA) begin
                        state_d = STOP;
                        bit_d   = '0;
                        err_d   = 1'b0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    cyc_d = cyc_q + CNT_W'(1);
                end
            end
            STOP: begin
                // Last stop sample lands mid-bit, so IDLE can catch an immediate start.
                if (cyc_q == CNT_BIT_END) begin
                    cyc_d = '0;
                    err_d = err_q | ~rxd_sync_q;
                    if (bit_q == LAST_STOP) begin
                        state_d = IDLE;
                        bit_d   = '0;
                        data_d  = shift_q;
                        ferr_d  = err_q | ~rxd_sync_q;
                        brk_d   = ferr_d & (shift_q == '0);
                        valid_d = 1'b1;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    cyc_d = cyc_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign uart_rx_data      = data_q;
    assign uart_rx_valid     = valid_q;
    assign uart_rx_frame_err = ferr_q;
    assign uart_rx_break     = brk_q;
    assign uart_rx_busy      = (state_q != IDLE);

endmodule
